// File: rtl/lrescue_input_mapper_pkg.sv
// lrescue_input_pkg
// Shared definitions for the Lunar Rescue input mapper:
//   - PS/2 set-2 scancode constants (prefixes and mapped keys)
//   - prefix-decoder and coin-stretcher state enums
//   - held-key vector indices and output bit positions
//   - helpers that classify a received scancode byte
package lrescue_input_pkg;

    // Prefix and protocol bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;

    // Mapped key codes (directions are shared by cursor keys and keypad)
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_START1 = 8'h16;
    localparam logic [7:0] SC_START2 = 8'h1E;
    localparam logic [7:0] SC_COIN1  = 8'h2E;
    localparam logic [7:0] SC_F12    = 8'h07;
    localparam logic [7:0] SC_F2     = 8'h06;

    typedef enum logic [1:0] {
        PFX_IDLE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXTBRK
    } prefix_state_t;

    typedef enum logic {
        COIN_IDLE,
        COIN_HOLD_ST
    } coin_state_t;

    // Held-key vector; indices 0..3 line up with player1/osd_o direction bits
    localparam int KEY_RIGHT   = 0;
    localparam int KEY_LEFT    = 1;
    localparam int KEY_DOWN    = 2;
    localparam int KEY_UP      = 3;
    localparam int KEY_CTRL    = 4;
    localparam int KEY_SPACE   = 5;
    localparam int KEY_ALT     = 6;
    localparam int KEY_START1  = 7;
    localparam int KEY_START2  = 8;
    localparam int KEY_COIN    = 9;
    localparam int KEY_OSD     = 10;
    localparam int KEY_SCANDBL = 11;
    localparam int NUM_KEYS    = 12;

    // player1 = {fireB, fireA, up, down, left, right}
    localparam int P1_FIRE_A = 4;
    localparam int P1_FIRE_B = 5;

    // joystick pin layout = {p6, p9, up, down, left, right}
    localparam int JOY_P9 = 4;
    localparam int JOY_P6 = 5;

    // controls = {coin1, start2, start1}
    localparam int CTL_START1 = 0;
    localparam int CTL_START2 = 1;
    localparam int CTL_COIN1  = 2;

    localparam int OSD_TOGGLE = 7;

    // Protocol bytes that abort any pending prefix and carry no key.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_E1) || (code == SC_AA) || (code == SC_FA) || (code == SC_FE);
    endfunction

    // One-hot held-key index for a key code. Directions and Ctrl/Alt accept
    // both the plain and E0 forms; the remaining keys only exist unextended.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code, input logic ext);
        logic [NUM_KEYS-1:0] hit;
        hit = '0;
        case (code)
            SC_UP:     hit[KEY_UP]      = 1'b1;
            SC_DOWN:   hit[KEY_DOWN]    = 1'b1;
            SC_LEFT:   hit[KEY_LEFT]    = 1'b1;
            SC_RIGHT:  hit[KEY_RIGHT]   = 1'b1;
            SC_CTRL:   hit[KEY_CTRL]    = 1'b1;
            SC_ALT:    hit[KEY_ALT]     = 1'b1;
            SC_SPACE:  hit[KEY_SPACE]   = !ext;
            SC_START1: hit[KEY_START1]  = !ext;
            SC_START2: hit[KEY_START2]  = !ext;
            SC_COIN1:  hit[KEY_COIN]    = !ext;
            SC_F12:    hit[KEY_OSD]     = !ext;
            SC_F2:     hit[KEY_SCANDBL] = !ext;
            default:   hit = '0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/lrescue_input_mapper_if.sv
// lrescue_kbd_if
// Byte stream from the PS/2 scancode receiver into the input mapper.
//   kbd_intr      one-cycle strobe, kbd_scancode valid in that cycle
//   kbd_scancode  raw set-2 byte
// master = receiver side, slave = mapper side.
interface lrescue_kbd_if;
    logic       kbd_intr;
    logic [7:0] kbd_scancode;

    modport master (output kbd_intr, output kbd_scancode);
    modport slave  (input kbd_intr, input kbd_scancode);
endinterface

// File: rtl/lrescue_input_mapper_sync_bus.sv
// lrescue_sync_bus
// N-bit multi-flop synchronizer for asynchronous pins.
//   clk_sys  system clock
//   reset    synchronous active-high reset, loads RESET_VALUE into every stage
//   d        asynchronous input bus
//   q        synchronized bus, STAGES cycles behind d
module lrescue_sync_bus #(
    parameter int               WIDTH       = 6,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VALUE;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/lrescue_input_mapper.sv
// lrescue_input_mapper
// Turns PS/2 set-2 scancodes plus two active-low DB9 joysticks into the
// active-high control set used by the Lunar Rescue core.
//   clk_sys         system clock
//   reset           synchronous active-high reset
//   kbd             scancode byte stream (lrescue_kbd_if.slave)
//   joy1_n, joy2_n  {p6,p9,up,down,left,right}, active-low, asynchronous
//   player1         {fireB,fireA,up,down,left,right}
//   controls        {coin1,start2,start1}; coin1 is stretched to COIN_HOLD cycles
//   osd_o           {F12 held, 3'b0, up,down,left,right}
//   scandbl_toggle  one-cycle pulse on a fresh F2 press
module lrescue_input_mapper
    import lrescue_input_pkg::*;
#(
    parameter logic [19:0] COIN_HOLD   = 20'd600000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    lrescue_kbd_if.slave       kbd,
    input  logic [5:0]         joy1_n,
    input  logic [5:0]         joy2_n,
    output logic [5:0]         player1,
    output logic [2:0]         controls,
    output logic [7:0]         osd_o,
    output logic               scandbl_toggle
);

    prefix_state_t        pfx_state;
    prefix_state_t        pfx_next;
    coin_state_t          coin_state;
    logic [19:0]          coin_cnt;
    logic [NUM_KEYS-1:0]  held;
    logic [NUM_KEYS-1:0]  held_next;
    logic [NUM_KEYS-1:0]  key_hit;
    logic [5:0]           joy1_sync_n;
    logic [5:0]           joy2_sync_n;
    logic [5:0]           joy1;
    logic [5:0]           joy2;
    logic [5:0]           p1_next;

    // Stages reset to all-ones so the released (idle-high) pins do not read
    // as pressed while the chain refills after reset.
    lrescue_sync_bus #(.WIDTH(6), .STAGES(SYNC_STAGES), .RESET_VALUE(6'h3F)) u_sync_joy1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (joy1_n),
        .q       (joy1_sync_n)
    );

    lrescue_sync_bus #(.WIDTH(6), .STAGES(SYNC_STAGES), .RESET_VALUE(6'h3F)) u_sync_joy2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (joy2_n),
        .q       (joy2_sync_n)
    );

    assign joy1 = ~joy1_sync_n;
    assign joy2 = ~joy2_sync_n;

    // Prefix decoder and held-key update. Outputs are registered from
    // held_next so the keyboard path lands on the edge after kbd_intr.
    always_comb begin
        pfx_next  = pfx_state;
        held_next = held;
        key_hit   = key_onehot(kbd.kbd_scancode,
                               (pfx_state == PFX_EXT) || (pfx_state == PFX_EXTBRK));
        if (kbd.kbd_intr) begin
            if (is_ignored(kbd.kbd_scancode)) begin
                pfx_next = PFX_IDLE;
            end else if ((pfx_state == PFX_IDLE) && (kbd.kbd_scancode == SC_E0)) begin
                pfx_next = PFX_EXT;
            end else if ((pfx_state == PFX_IDLE) && (kbd.kbd_scancode == SC_F0)) begin
                pfx_next = PFX_BRK;
            end else if ((pfx_state == PFX_EXT) && (kbd.kbd_scancode == SC_F0)) begin
                pfx_next = PFX_EXTBRK;
            end else begin
                if ((pfx_state == PFX_BRK) || (pfx_state == PFX_EXTBRK))
                    held_next = held & ~key_hit;
                else
                    held_next = held | key_hit;
                pfx_next = PFX_IDLE;
            end
        end
    end

    always_comb begin
        p1_next            = '0;
        p1_next[3:0]       = held_next[KEY_UP:KEY_RIGHT] | joy1[3:0] | joy2[3:0];
        p1_next[P1_FIRE_A] = held_next[KEY_CTRL] | held_next[KEY_SPACE] | joy1[JOY_P6] | joy2[JOY_P6];
        p1_next[P1_FIRE_B] = held_next[KEY_ALT] | joy1[JOY_P9] | joy2[JOY_P9];
    end

    // Registered outputs plus the coin stretcher. The stretcher only starts
    // on a fresh press from IDLE, and leaves HOLD only once the minimum
    // length has elapsed and the key is up, so presses during HOLD are ignored.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pfx_state      <= PFX_IDLE;
            held           <= '0;
            coin_state     <= COIN_IDLE;
            coin_cnt       <= '0;
            player1        <= '0;
            controls       <= '0;
            osd_o          <= '0;
            scandbl_toggle <= 1'b0;
        end else begin
            pfx_state              <= pfx_next;
            held                   <= held_next;
            player1                <= p1_next;
            controls[CTL_START1]   <= held_next[KEY_START1];
            controls[CTL_START2]   <= held_next[KEY_START2];
            osd_o                  <= {held_next[KEY_OSD], 3'b000, p1_next[3:0]};
            scandbl_toggle         <= held_next[KEY_SCANDBL] & ~held[KEY_SCANDBL];

            case (coin_state)
                COIN_IDLE: begin
                    if (held_next[KEY_COIN] && !held[KEY_COIN]) begin
                        coin_state          <= COIN_HOLD_ST;
                        coin_cnt            <= COIN_HOLD - 20'd1;
                        controls[CTL_COIN1] <= 1'b1;
                    end
                end
                COIN_HOLD_ST: begin
                    if (coin_cnt != 20'd0) begin
                        coin_cnt <= coin_cnt - 20'd1;
                    end else if (!held_next[KEY_COIN]) begin
                        coin_state          <= COIN_IDLE;
                        controls[CTL_COIN1] <= 1'b0;
                    end
                end
                default: begin
                    coin_state          <= COIN_IDLE;
                    controls[CTL_COIN1] <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lrescue_input_mapper.sv
// tb_lrescue_input_mapper
// Self-checking bench for lrescue_input_mapper (COIN_HOLD=10, SYNC_STAGES=2).
// Expected output bundles {player1, controls, osd_o, scandbl_toggle} are
// queued when stimulus is driven and popped when the DUT output is sampled.
module tb_lrescue_input_mapper;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [5:0] joy1_n;
    logic [5:0] joy2_n;
    logic [5:0] player1;
    logic [2:0] controls;
    logic [7:0] osd_o;
    logic       scandbl_toggle;

    int n_cmp = 0;
    int n_err = 0;
    int tog_seen = 0;
    int coin_high = 0;

    logic [17:0] exp_q[$];
    int          cnt_q[$];

    lrescue_kbd_if kbd_bus ();

    lrescue_input_mapper #(.COIN_HOLD(20'd10), .SYNC_STAGES(2)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .kbd            (kbd_bus),
        .joy1_n         (joy1_n),
        .joy2_n         (joy2_n),
        .player1        (player1),
        .controls       (controls),
        .osd_o          (osd_o),
        .scandbl_toggle (scandbl_toggle)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (scandbl_toggle === 1'b1) tog_seen++;
        if (controls[2] === 1'b1) coin_high++;
    end

    function automatic logic [17:0] outs();
        return {player1, controls, osd_o, scandbl_toggle};
    endfunction

    function automatic logic [17:0] mk(input logic [5:0] p1, input logic [2:0] ctl,
                                       input logic osd7, input logic tog);
        return {p1, ctl, osd7, 3'b000, p1[3:0], tog};
    endfunction

    // Called at a negedge; the byte is sampled on the next posedge and the
    // task returns at the following negedge, where the result is visible.
    task automatic send_byte(input logic [7:0] b);
        kbd_bus.kbd_intr     = 1'b1;
        kbd_bus.kbd_scancode = b;
        @(negedge clk_sys);
        kbd_bus.kbd_intr     = 1'b0;
        kbd_bus.kbd_scancode = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        logic [7:0]  seq [3] = '{8'h16, 8'hF0, 8'h16};
        logic [2:0]  ctl [3] = '{3'b001, 3'b001, 3'b000};
        logic [17:0] e;
        @(negedge clk_sys);
        reset = 1'b1;
        joy1_n = 6'h00;
        joy2_n = 6'h15;
        kbd_bus.kbd_intr = 1'b1;
        kbd_bus.kbd_scancode = 8'h16;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(18'h0);
            @(negedge clk_sys);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL reset_hold[%0d]: got %h want %h", i, outs(), e);
            end
        end
        reset = 1'b0;
        kbd_bus.kbd_intr = 1'b0;
        kbd_bus.kbd_scancode = 8'h00;
        joy1_n = 6'h3F;
        joy2_n = 6'h3F;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(18'h0);
            @(negedge clk_sys);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL reset_release[%0d]: got %h want %h", i, outs(), e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(6'h00, ctl[i], 1'b0, 1'b0));
            send_byte(seq[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL start1[%0d]: got %h want %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_directions();
        logic [7:0] seq [21] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75, 8'hF0, 8'h75,
                                 8'hE0, 8'h72, 8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hF0, 8'h72,
                                 8'hE0, 8'hF0, 8'h6B, 8'hF0, 8'h74};
        logic [5:0] p1 [21]  = '{6'h00, 6'h08, 6'h08, 6'h08, 6'h00, 6'h08, 6'h08, 6'h00,
                                 6'h00, 6'h04, 6'h04, 6'h06, 6'h06, 6'h07, 6'h07, 6'h03,
                                 6'h03, 6'h03, 6'h01, 6'h01, 6'h00};
        logic [17:0] e;
        for (int i = 0; i < 21; i++) begin
            exp_q.push_back(mk(p1[i], 3'b000, 1'b0, 1'b0));
            send_byte(seq[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL direction[%0d]: got %h want %h", i, outs(), e);
            end
        end
    endtask

    // Bit 8 set means one idle cycle instead of a byte.
    task automatic test_scandbl();
        logic [8:0] seq [9] = '{9'h006, 9'h100, 9'h006, 9'h0F0, 9'h006,
                                9'h006, 9'h100, 9'h0F0, 9'h006};
        logic       tog [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [17:0] e;
        int base;
        base = tog_seen;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mk(6'h00, 3'b000, 1'b0, tog[i]));
            if (seq[i][8]) idle(1);
            else send_byte(seq[i][7:0]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL scandbl[%0d]: got %h want %h", i, outs(), e);
            end
        end
        cnt_q.push_back(2);
        idle(2);
        n_cmp++;
        if ((tog_seen - base) !== cnt_q[0]) begin
            n_err++;
            $display("[TB] FAIL scandbl_pulses: got %0d want %0d", tog_seen - base, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
    endtask

    task automatic test_coin();
        int base;
        int want;
        logic [17:0] e;
        for (int s = 0; s < 3; s++) begin
            base = coin_high;
            want = (s == 1) ? 15 : 10;
            cnt_q.push_back(want);
            exp_q.push_back(mk(6'h00, 3'b100, 1'b0, 1'b0));
            send_byte(8'h2E);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL coin_press[%0d]: got %h want %h", s, outs(), e);
            end
            case (s)
                0: begin idle(3); send_byte(8'hF0); send_byte(8'h2E); end
                1: begin idle(13); send_byte(8'hF0); send_byte(8'h2E); end
                default: begin
                    send_byte(8'hF0); send_byte(8'h2E); send_byte(8'h2E);
                    idle(2); send_byte(8'hF0); send_byte(8'h2E);
                end
            endcase
            idle(20);
            want = cnt_q.pop_front();
            n_cmp++;
            if ((coin_high - base) !== want) begin
                n_err++;
                $display("[TB] FAIL coin_len[%0d]: got %0d want %0d", s, coin_high - base, want);
            end
        end
    endtask

    task automatic test_joystick();
        logic [5:0] j1 [4] = '{6'h3F, 6'h1F, 6'h2F, 6'h3F};
        logic [5:0] j2 [4] = '{6'h3D, 6'h3D, 6'h3D, 6'h3F};
        logic [5:0] p1 [5] = '{6'h00, 6'h02, 6'h12, 6'h22, 6'h00};
        logic [17:0] e;
        for (int i = 0; i < 4; i++) begin
            joy1_n = j1[i];
            joy2_n = j2[i];
            exp_q.push_back(mk(p1[i], 3'b000, 1'b0, 1'b0));
            exp_q.push_back(mk(p1[i+1], 3'b000, 1'b0, 1'b0));
            idle(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL joy_early[%0d]: got %h want %h", i, outs(), e);
            end
            idle(1);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL joy_latency[%0d]: got %h want %h", i, outs(), e);
            end
        end
        // Joystick right merged with keyboard left: both directions pass.
        joy1_n = 6'h3E;
        idle(3);
        exp_q.push_back(mk(6'h03, 3'b000, 1'b0, 1'b0));
        send_byte(8'hE0);
        send_byte(8'h6B);
        e = exp_q.pop_front();
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("[TB] FAIL joy_kbd_merge: got %h want %h", outs(), e);
        end
        joy1_n = 6'h3F;
        idle(3);
        exp_q.push_back(mk(6'h00, 3'b000, 1'b0, 1'b0));
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        e = exp_q.pop_front();
        n_cmp++;
        if (outs() !== e) begin
            n_err++;
            $display("[TB] FAIL joy_kbd_release: got %h want %h", outs(), e);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  pfx [2] = '{8'hE0, 8'hF0};
        logic [17:0] e;
        for (int i = 0; i < 2; i++) begin
            send_byte(pfx[i]);
            reset = 1'b1;
            exp_q.push_back(18'h0);
            idle(1);
            reset = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL mid_reset[%0d]: got %h want %h", i, outs(), e);
            end
            exp_q.push_back(mk(6'h08, 3'b000, 1'b0, 1'b0));
            send_byte(8'h75);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL mid_reset_make[%0d]: got %h want %h", i, outs(), e);
            end
            send_byte(8'hF0);
            send_byte(8'h75);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [24] = '{8'h14, 8'h29, 8'hF0, 8'h14, 8'hF0, 8'h29, 8'h11, 8'hF0,
                                 8'h11, 8'h07, 8'hF0, 8'h07, 8'hF0, 8'hE1, 8'h16, 8'h1E,
                                 8'hF0, 8'h16, 8'hF0, 8'h1E, 8'h2C, 8'hE0, 8'h14, 8'hAA};
        logic [5:0] p1 [24]  = '{6'h10, 6'h10, 6'h10, 6'h10, 6'h10, 6'h00, 6'h20, 6'h20,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h10, 6'h10};
        logic [2:0] ctl [24] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3,
                                 3'd3, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic       osd [24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [17:0] e;
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(mk(p1[i], ctl[i], osd[i], 1'b0));
            send_byte(seq[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_err++;
                $display("[TB] FAIL keys[%0d]: got %h want %h", i, outs(), e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        joy1_n = 6'h3F;
        joy2_n = 6'h3F;
        kbd_bus.kbd_intr = 1'b0;
        kbd_bus.kbd_scancode = 8'h00;
        test_reset();
        test_directions();
        test_scandbl();
        test_coin();
        test_joystick();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
